// File: rtl/cursor_paint_if.sv
// ============================================================================
//  Module      : cursor_paint_if
//  Description : Button/switch inputs and BRAM write port of the cursor painter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface cursor_paint_if;
    logic [3:0]  key_n;
    logic        sw_paint;
    logic [2:0]  sw_color;
    logic        uart_write_en;
    logic [9:0]  cursor_x;
    logic [8:0]  cursor_y;
    logic        cursor_write_en;
    logic [18:0] cursor_addr;
    logic [7:0]  cursor_data;

    modport master (
        input  key_n, sw_paint, sw_color, uart_write_en,
        output cursor_x, cursor_y, cursor_write_en, cursor_addr, cursor_data
    );

    modport slave (
        output key_n, sw_paint, sw_color, uart_write_en,
        input  cursor_x, cursor_y, cursor_write_en, cursor_addr, cursor_data
    );
endinterface

`default_nettype wire

// File: rtl/cursor_paint_ctrl.sv
// ============================================================================
//  Module      : cursor_paint_ctrl
//  Description : Debounced push-button cursor with optional single-pixel paint.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cursor_paint_ctrl #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int START_X         = 320,
    parameter int START_Y         = 240
) (
    input  wire logic      clk,
    input  wire logic      reset,
    cursor_paint_if.master bus
);

    localparam int          c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [9:0]  c_X_MAX   = 10'(H_RES - 1);
    localparam logic [8:0]  c_Y_MAX   = 9'(V_RES - 1);
    localparam logic [9:0]  c_X_START = 10'(START_X);
    localparam logic [8:0]  c_Y_START = 9'(START_Y);
    localparam logic [18:0] c_A_START = 19'(START_Y * H_RES + START_X);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_deb;
    logic [3:0]         r_deb_d;
    logic [c_CNT_W-1:0] r_cnt [4];
    logic [3:0]         w_press;

    // Key conditioning: 2-FF sync, then a level that only follows after a full stable window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_deb   <= 4'hF;
            r_deb_d <= 4'hF;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_LAST) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb_d & ~r_deb;

    state_t      r_state;
    logic [3:0]  r_pend;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_paint;
    logic [2:0]  r_color;
    logic [18:0] r_addr;
    logic [7:0]  r_data;
    logic [3:0]  w_serve;
    logic [18:0] w_addr;

    // Fixed priority: up > down > left > right.
    always_comb begin
        w_serve = 4'b0000;
        if (r_state == S_IDLE) begin
            if      (r_pend[0]) w_serve = 4'b0001;
            else if (r_pend[1]) w_serve = 4'b0010;
            else if (r_pend[2]) w_serve = 4'b0100;
            else if (r_pend[3]) w_serve = 4'b1000;
        end
    end

    assign w_addr = ({10'd0, r_y} << 9) + ({10'd0, r_y} << 7) + {9'd0, r_x};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= 4'b0000;
            r_x     <= c_X_START;
            r_y     <= c_Y_START;
            r_paint <= 1'b0;
            r_color <= 3'b000;
            r_addr  <= c_A_START;
            r_data  <= 8'h00;
        end else begin
            // A new press of the bit being served is kept rather than swallowed.
            r_pend <= (r_pend & ~w_serve) | w_press;
            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        if (w_serve[0] && r_y != 9'd0)    r_y <= r_y - 1'b1;
                        if (w_serve[1] && r_y != c_Y_MAX) r_y <= r_y + 1'b1;
                        if (w_serve[2] && r_x != 10'd0)   r_x <= r_x - 1'b1;
                        if (w_serve[3] && r_x != c_X_MAX) r_x <= r_x + 1'b1;
                        r_paint <= bus.sw_paint;
                        r_color <= bus.sw_color;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_addr  <= w_addr;
                    r_data  <= {5'b00000, r_color};
                    r_state <= r_paint ? S_WRITE : S_IDLE;
                end
                S_WRITE: begin
                    if (!bus.uart_write_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobe follows the UART busy flag within the cycle so the write lands on the first free slot.
    assign bus.cursor_write_en = (r_state == S_WRITE) && !bus.uart_write_en;
    assign bus.cursor_x        = r_x;
    assign bus.cursor_y        = r_y;
    assign bus.cursor_addr     = r_addr;
    assign bus.cursor_data     = r_data;

endmodule

`default_nettype wire

// File: tb/tb_cursor_paint_ctrl.sv
// ============================================================================
//  Module      : tb_cursor_paint_ctrl
//  Description : Directed self-checking bench for cursor_paint_ctrl.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cursor_paint_ctrl;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;
    int   w0;

    always #5 clk = ~clk;

    cursor_paint_if bus ();

    cursor_paint_ctrl #(
        .H_RES(640), .V_RES(480), .DEBOUNCE_CYCLES(D), .START_X(320), .START_Y(240)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clk) if (bus.cursor_write_en === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic wait_move(input string tag);
        logic [18:0] p0;
        p0 = {bus.cursor_x, bus.cursor_y};
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({bus.cursor_x, bus.cursor_y} !== p0) return;
        end
        errors++; checks++;
        $display("FAIL %s_timeout: got no move in 200 cycles, want a move", tag);
    endtask

    task automatic press(input logic [3:0] mask);
        bus.key_n = ~mask;
        repeat (24) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cursor_x !== 10'd320) begin errors++; $display("FAIL reset_x: got %0d want 320", bus.cursor_x); end
        checks++; if (bus.cursor_y !== 9'd240) begin errors++; $display("FAIL reset_y: got %0d want 240", bus.cursor_y); end
        checks++; if (bus.cursor_addr !== 19'd153920) begin errors++; $display("FAIL reset_addr: got %0d want 153920", bus.cursor_addr); end
        checks++; if (bus.cursor_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.cursor_data); end
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.cursor_write_en); end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        bit changed = 0;
        w0 = wr_cnt;
        repeat (10000) begin
            @(negedge clk);
            if (bus.cursor_x !== 10'd320 || bus.cursor_y !== 9'd240 || bus.cursor_addr !== 19'd153920) changed = 1;
        end
        checks++; if (changed) begin errors++; $display("FAIL idle_stable: got changed=1 want 0"); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL idle_writes: got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_debounce;
        w0 = wr_cnt;
        bus.key_n = 4'b1110;
        repeat (10) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (30) @(negedge clk);
        checks++; if (bus.cursor_y !== 9'd240) begin errors++; $display("FAIL deb_glitch_y: got %0d want 240", bus.cursor_y); end
        bus.key_n = 4'b1110;
        repeat (40) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (30) @(negedge clk);
        checks++; if (bus.cursor_y !== 9'd239) begin errors++; $display("FAIL deb_press_y: got %0d want 239", bus.cursor_y); end
        checks++; if (bus.cursor_x !== 10'd320) begin errors++; $display("FAIL deb_press_x: got %0d want 320", bus.cursor_x); end
        checks++; if (bus.cursor_addr !== 19'd153280) begin errors++; $display("FAIL deb_addr: got %0d want 153280", bus.cursor_addr); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL deb_no_write: got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_paint;
        bus.sw_paint = 1'b1;
        bus.sw_color = 3'b100;
        w0 = wr_cnt;
        bus.key_n = 4'b0111;
        wait_move("paint");
        checks++; if (bus.cursor_x !== 10'd321) begin errors++; $display("FAIL paint_x: got %0d want 321", bus.cursor_x); end
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL paint_we_c0: got %b want 0", bus.cursor_write_en); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b1) begin errors++; $display("FAIL paint_we_c1: got %b want 1", bus.cursor_write_en); end
        checks++; if (bus.cursor_addr !== 19'd153281) begin errors++; $display("FAIL paint_addr: got %0d want 153281", bus.cursor_addr); end
        checks++; if (bus.cursor_data !== 8'h04) begin errors++; $display("FAIL paint_data: got %h want 04", bus.cursor_data); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL paint_we_c2: got %b want 0", bus.cursor_write_en); end
        bus.key_n = 4'hF;
        repeat (30) @(negedge clk);
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL paint_count: got %0d want %0d", wr_cnt, w0 + 1); end
    endtask

    task automatic test_uart;
        bus.uart_write_en = 1'b1;
        w0 = wr_cnt;
        bus.key_n = 4'b1011;
        wait_move("uart");
        checks++; if (bus.cursor_x !== 10'd320) begin errors++; $display("FAIL uart_x: got %0d want 320", bus.cursor_x); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL uart_hold_%0d: got %b want 0", i, bus.cursor_write_en); end
        end
        bus.uart_write_en = 1'b0;
        #1;
        checks++; if (bus.cursor_write_en !== 1'b1) begin errors++; $display("FAIL uart_release_we: got %b want 1", bus.cursor_write_en); end
        checks++; if (bus.cursor_addr !== 19'd153280) begin errors++; $display("FAIL uart_addr: got %0d want 153280", bus.cursor_addr); end
        checks++; if (bus.cursor_data !== 8'h04) begin errors++; $display("FAIL uart_data: got %h want 04", bus.cursor_data); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL uart_after_we: got %b want 0", bus.cursor_write_en); end
        bus.key_n = 4'hF;
        repeat (30) @(negedge clk);
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL uart_count: got %0d want %0d", wr_cnt, w0 + 1); end
    endtask

    task automatic test_saturation;
        bus.sw_paint = 1'b0;
        repeat (330) press(4'b0101);
        checks++; if (bus.cursor_x !== 10'd0) begin errors++; $display("FAIL sat_min_x: got %0d want 0", bus.cursor_x); end
        checks++; if (bus.cursor_y !== 9'd0) begin errors++; $display("FAIL sat_min_y: got %0d want 0", bus.cursor_y); end
        checks++; if (bus.cursor_addr !== 19'd0) begin errors++; $display("FAIL sat_min_addr: got %0d want 0", bus.cursor_addr); end
        repeat (650) press(4'b1010);
        checks++; if (bus.cursor_x !== 10'd639) begin errors++; $display("FAIL sat_max_x: got %0d want 639", bus.cursor_x); end
        checks++; if (bus.cursor_y !== 9'd479) begin errors++; $display("FAIL sat_max_y: got %0d want 479", bus.cursor_y); end
        checks++; if (bus.cursor_addr !== 19'd307199) begin errors++; $display("FAIL sat_max_addr: got %0d want 307199", bus.cursor_addr); end
        bus.sw_paint = 1'b1;
        w0 = wr_cnt;
        press(4'b1000);
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL sat_edge_write: got %0d want %0d", wr_cnt, w0 + 1); end
        checks++; if (bus.cursor_addr !== 19'd307199) begin errors++; $display("FAIL sat_edge_addr: got %0d want 307199", bus.cursor_addr); end
        checks++; if (bus.cursor_x !== 10'd639) begin errors++; $display("FAIL sat_edge_x: got %0d want 639", bus.cursor_x); end
    endtask

    task automatic test_simultaneous;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.sw_paint = 1'b1;
        bus.sw_color = 3'b010;
        w0 = wr_cnt;
        bus.key_n = 4'b0110;
        wait_move("simul");
        checks++; if (bus.cursor_y !== 9'd239 || bus.cursor_x !== 10'd320) begin errors++; $display("FAIL simul_first: got (%0d,%0d) want (320,239)", bus.cursor_x, bus.cursor_y); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b1) begin errors++; $display("FAIL simul_we1: got %b want 1", bus.cursor_write_en); end
        checks++; if (bus.cursor_addr !== 19'd153280) begin errors++; $display("FAIL simul_addr1: got %0d want 153280", bus.cursor_addr); end
        checks++; if (bus.cursor_data !== 8'h02) begin errors++; $display("FAIL simul_data: got %h want 02", bus.cursor_data); end
        @(negedge clk);
        checks++; if (bus.cursor_x !== 10'd320) begin errors++; $display("FAIL simul_x_wait: got %0d want 320", bus.cursor_x); end
        @(negedge clk);
        checks++; if (bus.cursor_x !== 10'd321) begin errors++; $display("FAIL simul_x_second: got %0d want 321", bus.cursor_x); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b1) begin errors++; $display("FAIL simul_we2: got %b want 1", bus.cursor_write_en); end
        checks++; if (bus.cursor_addr !== 19'd153281) begin errors++; $display("FAIL simul_addr2: got %0d want 153281", bus.cursor_addr); end
        bus.key_n = 4'hF;
        repeat (30) @(negedge clk);
        checks++; if (wr_cnt !== w0 + 2) begin errors++; $display("FAIL simul_count: got %0d want %0d", wr_cnt, w0 + 2); end
    endtask

    task automatic test_reset_mid_write;
        bus.uart_write_en = 1'b1;
        bus.key_n = 4'b1101;
        wait_move("midrst");
        bus.key_n = 4'hF;
        checks++; if (bus.cursor_y !== 9'd240) begin errors++; $display("FAIL midrst_y: got %0d want 240", bus.cursor_y); end
        @(negedge clk);
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL midrst_hold: got %b want 0", bus.cursor_write_en); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.cursor_x !== 10'd320 || bus.cursor_y !== 9'd240) begin errors++; $display("FAIL midrst_pos: got (%0d,%0d) want (320,240)", bus.cursor_x, bus.cursor_y); end
        checks++; if (bus.cursor_addr !== 19'd153920) begin errors++; $display("FAIL midrst_addr: got %0d want 153920", bus.cursor_addr); end
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b want 0", bus.cursor_write_en); end
        reset = 1'b0;
        bus.uart_write_en = 1'b0;
        w0 = wr_cnt;
        #1;
        checks++; if (bus.cursor_write_en !== 1'b0) begin errors++; $display("FAIL midrst_we_post: got %b want 0", bus.cursor_write_en); end
        repeat (40) @(negedge clk);
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL midrst_count: got %0d want %0d", wr_cnt, w0); end
        checks++; if (bus.cursor_y !== 9'd240) begin errors++; $display("FAIL midrst_y_after: got %0d want 240", bus.cursor_y); end
    endtask

    initial begin
        bus.key_n         = 4'hF;
        bus.sw_paint      = 1'b0;
        bus.sw_color      = 3'b000;
        bus.uart_write_en = 1'b0;
        test_reset();
        test_idle();
        test_debounce();
        test_paint();
        test_uart();
        test_saturation();
        test_simultaneous();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
